// File: rtl/popcount_8bit_lut.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_8bit_lut
//  Purpose  : Combinational population count of one byte. Each nibble is
//             looked up in a 16-entry table and the two partial counts are
//             added, giving a result in the range 0..8.
//  Ports    : data_i  [7:0]  byte to count
//             count_o [3:0]  number of set bits in data_i
//  Revision : 1.0 - initial release
// ============================================================================
module popcount_8bit_lut (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  function automatic logic [3:0] nibble_count(input logic [3:0] nib);
    logic [3:0] cnt;
    case (nib)
      4'h0: cnt = 4'd0;
      4'h1: cnt = 4'd1;
      4'h2: cnt = 4'd1;
      4'h3: cnt = 4'd2;
      4'h4: cnt = 4'd1;
      4'h5: cnt = 4'd2;
      4'h6: cnt = 4'd2;
      4'h7: cnt = 4'd3;
      4'h8: cnt = 4'd1;
      4'h9: cnt = 4'd2;
      4'hA: cnt = 4'd2;
      4'hB: cnt = 4'd3;
      4'hC: cnt = 4'd2;
      4'hD: cnt = 4'd3;
      4'hE: cnt = 4'd3;
      default: cnt = 4'd4;
    endcase
    return cnt;
  endfunction

  always_comb begin
    count_o = nibble_count(data_i[3:0]) + nibble_count(data_i[7:4]);
  end

endmodule
`default_nettype wire

// File: rtl/popcount_stream_accum.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_stream_accum
//  Purpose  : Streaming popcount accumulator. Bytes framed by in_last are
//             registered (stage A), reduced to a bit count and summed into a
//             saturating frame accumulator. The frame total is delivered
//             through a single result register with valid/ready backpressure.
//  Ports    : clk        clock, rising edge
//             rst        synchronous active-high reset
//             in_valid   in_data/in_last valid
//             in_ready   a byte can be accepted this cycle
//             in_data    [7:0] byte to count
//             in_last    byte ends the frame
//             out_valid  frame result held in the result register
//             out_ready  consumer accepts the result
//             out_sum    [SUM_W-1:0] saturated frame bit count
//             out_sat    saturation occurred in this frame
//  Revision : 1.0 - initial release
// ============================================================================
module popcount_stream_accum #(
  parameter int SUM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_sat
);

  localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

  // Stage A
  logic             a_valid_q, a_valid_d;
  logic [7:0]       a_data_q,  a_data_d;
  logic             a_last_q,  a_last_d;

  // Frame accumulator
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;

  // Result register
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] out_sum_q,   out_sum_d;
  logic             out_sat_q,   out_sat_d;

  logic [3:0]       pc;
  logic [SUM_W:0]   nxt;
  logic             ovf;
  logic [SUM_W-1:0] result;
  logic             a_adv;
  logic             a_fire;

  popcount_8bit_lut u_popcount (
    .data_i  (a_data_q),
    .count_o (pc)
  );

  // Only a last byte needs the result register; it must wait while an
  // unconsumed result is held. Non-last bytes always drain into the
  // accumulator.
  assign a_adv    = !(a_valid_q && a_last_q && out_valid_q && !out_ready);
  assign a_fire   = a_valid_q && a_adv;
  assign in_ready = !rst && (!a_valid_q || a_adv);

  // One extra bit of headroom exposes overflow as the top bit.
  assign nxt    = {1'b0, acc_q} + {{(SUM_W-3){1'b0}}, pc};
  assign ovf    = nxt[SUM_W];
  assign result = ovf ? SUM_MAX : nxt[SUM_W-1:0];

  always_comb begin
    a_valid_d   = a_valid_q;
    a_data_d    = a_data_q;
    a_last_d    = a_last_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q && !out_ready;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;

    if (in_ready) begin
      a_valid_d = in_valid;
      if (in_valid) begin
        a_data_d = in_data;
        a_last_d = in_last;
      end
    end

    if (a_fire) begin
      if (a_last_q) begin
        // A load in the same cycle as consumption keeps out_valid high.
        out_valid_d = 1'b1;
        out_sum_d   = result;
        out_sat_d   = sat_q | ovf;
        acc_d       = '0;
        sat_d       = 1'b0;
      end else begin
        acc_d = result;
        sat_d = sat_q | ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q   <= 1'b0;
      a_data_q    <= '0;
      a_last_q    <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_data_q    <= a_data_d;
      a_last_q    <= a_last_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: doc/popcount_stream_accum.md
# popcount_stream_accum

Streaming popcount accumulator that consumes a byte stream framed by `in_last` and returns one population-count total per frame. It sits directly downstream of the 8-bit popcount stage: each accepted byte is registered, reduced to a 4-bit count, and summed into a frame accumulator. Input and output use valid/ready handshakes, and the output is buffered in one result register with backpressure. It serves as the sequential popcount benchmark for PIM synthesis.

## Interface
- `SUM_W`, default 16: accumulator and result width. Legal values are ≥ 4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: `in_data` and `in_last` are valid.
- `in_ready` output 1: the block can accept a byte this cycle.
- `in_data` input 8: byte to count.
- `in_last` input 1: this byte ends the frame.
- `out_valid` output 1: frame result is held in the result register.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output SUM_W: total set bits in the frame, saturated.
- `out_sat` output 1: saturation occurred in this frame.

## Operation
- Input handshake: a byte is accepted when `in_valid && in_ready` at a rising edge.
- Output handshake: a result is consumed when `out_valid && out_ready` at a rising edge.
- **Stage A (input register)**
  - Holds `a_valid`, `a_data[7:0]`, `a_last`.
  - Advances (`a_adv`) unless `a_valid && a_last && out_valid && !out_ready`.
  - `in_ready = !rst && (!a_valid || a_adv)`, combinational from `out_ready`.
- **Stage B (accumulate)**, when `a_valid && a_adv`:
  - `pc = popcount(a_data)`, 0..8.
  - `nxt = acc + pc`, computed at SUM_W+1 bits.
  - If `nxt > SUM_MAX` (2^SUM_W−1): result is SUM_MAX and the frame saturation flag is set.
  - Not last: `acc <= result`, `sat <= sat | ovf`.
  - Last: `out_sum <= result`, `out_sat <= sat | ovf`, `out_valid <= 1`, `acc <= 0`, `sat <= 0`.
- **Result register**
  - `out_valid` clears on consumption unless a new result loads in the same cycle; a simultaneous load wins.
  - `out_sum` and `out_sat` hold their values while `out_valid` is low.
- **Framing**
  - A one-byte frame (`in_last` on the first byte) is legal.
  - Back-to-back frames need no idle cycle.
  - Zero-length frames do not exist.
- **Reset**
  - `rst` high clears `a_valid`, `acc`, `sat`, `out_valid`, `out_sum`, `out_sat` to 0 at the next edge.
  - `in_ready` is forced 0 while `rst` is high.
  - Reset mid-frame discards the partial sum and any unconsumed result.

## Timing
- Reset values: `in_ready` 0 while `rst` is high, 1 in the first cycle after release. `out_valid` 0, `out_sum` 0, `out_sat` 0.
- Latency: last byte accepted in cycle N → `out_valid` high in cycle N+2, provided the result register is free.
- Throughput: 1 byte/cycle sustained, including across frame boundaries, while `out_ready` is high.
- Stall: with `out_valid` high and `out_ready` low, a last byte waits in stage A and `in_ready` drops in that same cycle. Non-last bytes in stage A still advance.
- Ordering: results are never dropped, duplicated, or reordered.

## Structure
- No shared package. The only constant is `localparam SUM_MAX = {SUM_W{1'b1}}`.
- One sub-module: `popcount_8bit_lut` on `a_data`, instantiated unmodified.
- Stage A, the accumulator, and the result register live in this module.

## Test plan
- **Reset:** hold `rst` 3 cycles → `in_ready` 0 and all outputs 0 throughout. Release → `in_ready` 1 in the first cycle after release.
- **Basic frame:** 0xFF, 0x0F, 0x01(last) on consecutive cycles, `out_ready`=1 → `out_sum`=13, `out_sat`=0, `out_valid` 2 cycles after the last handshake, high 1 cycle.
- **Back-to-back one-byte frames:** 0x00(last), 0xAA(last), 0x55(last) → results 0, 4, 4 on consecutive cycles.
- **Backpressure:** `out_ready`=0, frames {0x03(last)} and {0x07, 0x01(last)} → first result held; `in_ready` drops while the second last byte sits in stage A. Raise `out_ready` → results 2 then 4, in order, with no loss.
- **Saturation (SUM_W=4):**
  - 0xFF, 0xFF(last) → `out_sum`=15, `out_sat`=1.
  - Next frame 0x03(last) → 2, `out_sat`=0.
- **Reset mid-frame:**
  - 0xFF, 0xFF accepted, then `rst` 1 cycle → no output.
  - Then 0x01(last) → `out_sum`=1.
